// File: rtl/switch_seq_pkg.sv
// -----------------------------------------------------------------------------
// switch_seq_pkg
// Constants and types shared by the switch-input front end and the
// switch_sequence_player playback engine.
//   state_t      : playback FSM states
//   BLANK_DIGIT  : hex code driven when no digit is being shown
//   MAX_DIGITS   : number of digits held in a packed sequence
//   NUM_SW       : number of board switches / LEDs
//   DIGIT_W      : width of one packed digit
// -----------------------------------------------------------------------------
package switch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_DIGIT     = 4'hF;
    localparam int         MAX_DIGITS      = 4;
    localparam int         NUM_SW          = 10;
    localparam int         DIGIT_W         = 4;
    localparam logic [3:0] MAX_VALID_DIGIT = 4'd9;

    // A digit can be shown on the LEDs only if it names an existing switch.
    function automatic logic digit_is_valid(input logic [DIGIT_W-1:0] digit);
        return (digit <= MAX_VALID_DIGIT);
    endfunction

endpackage

// File: rtl/switch_sequence_player_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Down-counting interval timer. A load writes load_val; otherwise the count
// decrements once per cycle and sticks at zero.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset, count returns to 0
//   load     : load load_val into the counter this cycle
//   load_val : value to load
//   expired  : high while the count is 0
// -----------------------------------------------------------------------------
module cycle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Countdown register: load has priority, then decrement until zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/switch_sequence_player.sv
// -----------------------------------------------------------------------------
// switch_sequence_player
// Replays a captured switch sequence as one-hot LED patterns. START in IDLE
// snapshots SEQUENCE and the (clamped) digit count; each digit is then shown
// for DWELL_CYCLES, with GAP_CYCLES of blank between digits, and a one-cycle
// DONE marks the end. Invalid digits (>9) show blank and pulse ERR once.
// Ports:
//   CLK          : clock
//   RESET        : synchronous active-high reset, aborts playback
//   START        : playback request, honoured only in IDLE
//   SEQUENCE     : packed digits, digit k in [4k+3:4k], digit 0 first
//   SEQUENCE_BIT : number of valid digits, clamped to MAX_DIGITS
//   LEDR         : one-hot LED of the digit being shown, 0 otherwise
//   DIGIT_HEX    : digit being shown, 4'hF when blank
//   BUSY         : high from the first to the last SHOW cycle
//   DONE         : one-cycle pulse at the end of a playback
//   ERR          : one-cycle pulse on entering SHOW with an invalid digit
// All outputs are registered.
// -----------------------------------------------------------------------------
module switch_sequence_player #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 12_500_000,
    parameter int MAX_DIGITS   = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              START,
    input  logic [4*MAX_DIGITS-1:0]           SEQUENCE,
    input  logic [2:0]                        SEQUENCE_BIT,
    output logic [switch_seq_pkg::NUM_SW-1:0] LEDR,
    output logic [3:0]                        DIGIT_HEX,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              ERR
);

    import switch_seq_pkg::*;

    localparam int SEQ_W   = DIGIT_W * MAX_DIGITS;
    localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       CNT_MAX    = 3'(MAX_DIGITS);
    localparam logic [NUM_SW-1:0] LED_ONE   = {{(NUM_SW-1){1'b0}}, 1'b1};

    // Registered state
    state_t            state_r;
    logic [SEQ_W-1:0]  seq_r;
    logic [2:0]        cnt_r;
    logic [IDX_W-1:0]  idx_r;

    // Next-state and next-output values
    state_t            state_s;
    logic [SEQ_W-1:0]  seq_s;
    logic [2:0]        cnt_s;
    logic [IDX_W-1:0]  idx_s;
    logic [2:0]        clamp_s;
    logic              last_s;
    logic              tmr_load_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic              tmr_expired_s;
    logic [DIGIT_W-1:0] digit_s;
    logic [NUM_SW-1:0] led_s;
    logic [3:0]        hex_s;
    logic              busy_s;
    logic              done_s;
    logic              err_s;

    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (CLK),
        .reset    (RESET),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expired  (tmr_expired_s)
    );

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_s    = state_r;
        seq_s      = seq_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = {TMR_W{1'b0}};
        done_s     = 1'b0;
        clamp_s    = (SEQUENCE_BIT > CNT_MAX) ? CNT_MAX : SEQUENCE_BIT;
        last_s     = (3'(idx_r) == (cnt_r - 3'd1));

        case (state_r)
            IDLE: begin
                if (START) begin
                    seq_s = SEQUENCE;
                    cnt_s = clamp_s;
                    idx_s = {IDX_W{1'b0}};
                    if (clamp_s == 3'd0) begin
                        // Nothing to play: finish immediately.
                        done_s = 1'b1;
                    end else begin
                        state_s    = SHOW;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = DWELL_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHOW: begin
                if (tmr_expired_s) begin
                    if (last_s) begin
                        // No gap after the final digit.
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s    = GAP;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = GAP_LOAD;
                    end
                end else begin
                    state_s = SHOW;
                end
            end
            GAP: begin
                if (tmr_expired_s) begin
                    idx_s      = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_s    = SHOW;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DWELL_LOAD;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        digit_s = seq_s[DIGIT_W*idx_s +: DIGIT_W];

        if ((state_s == SHOW) && digit_is_valid(digit_s)) begin
            led_s = LED_ONE << digit_s;
            hex_s = digit_s;
        end else begin
            led_s = {NUM_SW{1'b0}};
            hex_s = BLANK_DIGIT;
        end

        busy_s = (state_s != IDLE);
        // ERR fires only on the cycle a SHOW begins, not for its whole dwell.
        err_s  = (state_s == SHOW) && (state_r != SHOW) && !digit_is_valid(digit_s);
    end

    // State, snapshot and registered output update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            seq_r     <= {SEQ_W{1'b0}};
            cnt_r     <= 3'd0;
            idx_r     <= {IDX_W{1'b0}};
            LEDR      <= {NUM_SW{1'b0}};
            DIGIT_HEX <= BLANK_DIGIT;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state_r   <= state_s;
            seq_r     <= seq_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            LEDR      <= led_s;
            DIGIT_HEX <= hex_s;
            BUSY      <= busy_s;
            DONE      <= done_s;
            ERR       <= err_s;
        end
    end

endmodule
